aes_key_sched: RTL
==================

# aes_key_sched

On-the-fly AES-128 key schedule and round sequencer for the iterative encryption datapath. On a start pulse it latches the 128-bit cipher key and then delivers one round key per clock (RK1..RK10), together with the matching round index. The middle-round stage and the final-round stage consume `round_sel`/`round_key` directly; the final-round stage adds `round_key` at `round_sel == 9`. The block is the sole source of `round_sel` and `round_key` for those stages.

## Interface
- No parameters; fixed to AES-128 (10 rounds).
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle request; accepted only when `busy == 0`.
- `key_in`  in  128  cipher key, sampled on the accepted `start` edge; byte 0 in [127:120].
- `key0`  out  128  latched cipher key (RK0) for the initial AddRoundKey; held until the next accepted start.
- `round_key`  out  128  round key RK(`round_sel`+1) while busy; 0 when idle.
- `round_sel`  out  4  round index 0..9 while busy; 4'hF when idle.
- `busy`  out  1  schedule in progress.
- `done`  out  1  one-cycle pulse on the first idle cycle after round 9.

## Operation
- Two states: IDLE and RUN. All outputs are registered.
- IDLE: `round_sel`=4'hF, `round_key`=0, `busy`=0. The idle index is deliberately not 9, so downstream stages stay cleared.
- `start` in IDLE causes the following updates on the next edge:
  - `key0` <= `key_in`.
  - `round_key` <= expand(`key_in`, rcon[1]).
  - `round_sel` <= 0, `busy` <= 1.
  - State moves to RUN.
- RUN with `round_sel` < 9: `round_key` <= expand(`round_key`, rcon[`round_sel`+2]) and `round_sel` <= `round_sel`+1.
- RUN with `round_sel` == 9: on the next edge `round_sel` <= 4'hF, `round_key` <= 0, `busy` <= 0, `done` <= 1. State moves to IDLE.
- `done` is 0 in every other cycle.
- `start` while `busy` is ignored entirely: `key0` and the sequence are unaffected.
- `start` in the cycle where `done` = 1 is accepted, since `busy` is already 0.
- expand(K, rc):
  - Words: w0=K[127:96], w1=K[95:64], w2=K[63:32], w3=K[31:0].
  - t = SubWord(RotWord(w3)) ^ {rc, 24'h0}, where RotWord({a,b,c,d}) = {b,c,d,a}.
  - SubWord applies the AES S-box to each byte; use four existing `s_box` instances.
  - n0=w0^t; n1=w1^n0; n2=w2^n1; n3=w3^n2; result {n0,n1,n2,n3}.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36. Implement as an 8-bit lookup indexed by the round counter; only indices 1..10 are reachable.
- All XOR arithmetic is 128/32/8-bit with no carries; width mismatches are not permitted.

## Timing
- Reset values: `key0`=0, `round_key`=0, `round_sel`=4'hF, `busy`=0, `done`=0, state IDLE.
- Assertion of `rst_n` mid-run returns every output to its reset value immediately (asynchronous). No partial sequence resumes.
- Latency, with start sampled at edge E0:
  - At E1, `round_sel`=0 and `round_key`=RK1.
  - At E1+k, `round_sel`=k and `round_key`=RK(k+1).
  - At E10, `round_sel`=9 and `round_key`=RK10.
  - At E11, the block is idle with `done`=1; at E12, `done`=0.
- Throughput: one key schedule per 11 cycles. Back-to-back operation is possible when `start` coincides with `done`.
- Critical path: S-box, then 4-deep XOR chain, then the register. There is one expansion per cycle.

## Test plan
- Reset then idle: hold `rst_n`=0, release, wait 5 cycles -> `round_sel`=F, `round_key`=0, `busy`=0, `done`=0 throughout.
- FIPS-197 key: `key_in`=2b7e151628aed2a6abf7158809cf4f3c -> the following values appear:
  - `key0` = that key.
  - Round 0: a0fafe1788542cb123a339392a6c7605.
  - Round 1: f2c295f27a96b9435935807a7359f67f.
  - Round 9: d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `done` at E11.
- Zero key -> round 0 key 62636363626363636263636362636363; round 9 key b4ef5bcb3e92e21123e951cf6f8f188e.
- `start` with a different key at `round_sel`=4 -> ignored; the remaining keys match the first key; `key0` is unchanged.
- `start` in the `done` cycle with the zero key -> the new sequence begins the next cycle (`round_sel`=0, RK1 of the zero key); `busy` dips for only that one cycle.
- `rst_n` pulsed low at `round_sel`=6 -> all outputs go to reset values immediately; no `done`; a subsequent start runs a full correct sequence.

Source files
------------

// File: rtl/aes_key_sched_if.sv
// Handshake and key bus between the AES key scheduler and its requester and consumers.
// The requester drives start/key_in; the scheduler drives everything else.
interface aes_key_sched_if;
    logic         start;
    logic [127:0] key_in;
    logic [127:0] key0;
    logic [127:0] round_key;
    logic [3:0]   round_sel;
    logic         busy;
    logic         done;

    modport master (
        output start, key_in,
        input  key0, round_key, round_sel, busy, done
    );

    modport slave (
        input  start, key_in,
        output key0, round_key, round_sel, busy, done
    );
endinterface

// File: rtl/aes_key_sched.sv
// On-the-fly AES-128 key schedule: latches the cipher key on start and then
// emits RK1..RK10 one per clock together with the round index.
module aes_key_sched (
    input  logic             clk,
    input  logic             rst_n,
    aes_key_sched_if.slave   ks
);
    typedef enum logic {S_IDLE, S_RUN} state_e;

    localparam logic [3:0] SEL_IDLE = 4'hF;
    localparam logic [3:0] SEL_LAST = 4'd9;

    state_e       state_q, state_d;
    logic [127:0] key0_q, key0_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   sel_q, sel_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [127:0] exp_src;
    logic [3:0]   rc_idx;
    logic [7:0]   rc;
    logic [31:0]  rot_w, sub_w, t_w;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] exp_key;

    function automatic logic [7:0] rcon_lut(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1B;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // In IDLE the expansion runs on the incoming key so RK1 is ready at the first RUN edge.
    assign exp_src = (state_q == S_IDLE) ? ks.key_in : rk_q;
    assign rc_idx  = (state_q == S_IDLE) ? 4'd1 : (sel_q + 4'd2);
    assign rc      = rcon_lut(rc_idx);
    assign rot_w   = {exp_src[23:0], exp_src[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            s_box u_sbox (
                .a_i (rot_w[8*gi +: 8]),
                .y_o (sub_w[8*gi +: 8])
            );
        end
    endgenerate

    assign t_w     = sub_w ^ {rc, 24'h000000};
    assign n0      = exp_src[127:96] ^ t_w;
    assign n1      = exp_src[95:64]  ^ n0;
    assign n2      = exp_src[63:32]  ^ n1;
    assign n3      = exp_src[31:0]   ^ n2;
    assign exp_key = {n0, n1, n2, n3};

    always_comb begin
        state_d = state_q;
        key0_d  = key0_q;
        rk_d    = rk_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ks.start) begin
                    key0_d  = ks.key_in;
                    rk_d    = exp_key;
                    sel_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (sel_q == SEL_LAST) begin
                    rk_d    = '0;
                    sel_d   = SEL_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    rk_d  = exp_key;
                    sel_d = sel_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            key0_q  <= '0;
            rk_q    <= '0;
            sel_q   <= SEL_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key0_q  <= key0_d;
            rk_q    <= rk_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ks.key0      = key0_q;
    assign ks.round_key = rk_q;
    assign ks.round_sel = sel_q;
    assign ks.busy      = busy_q;
    assign ks.done      = done_q;
endmodule

// AES S-box computed as GF(2^8) inverse (x^254) followed by the affine transform.
module s_box (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] aa;
        logic [7:0] p;
        aa = a;
        p  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] inv;
    logic [7:0] sq;

    // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as the S-box requires.
    always_comb begin
        sq  = a_i;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
    end

    assign y_o = inv
               ^ {inv[6:0], inv[7]}
               ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]}
               ^ 8'h63;
endmodule
